ifetch_pc_gen: RTL and testbench
================================

// Module: ifetch_pc_gen
// PURPOSE
//  Instruction-fetch stage: owns the program counter, drives the word address into the
//  instruction ROM and pairs the ROM's returned word with its PC for the decode stage.
//  The ROM registers the address on each posedge and returns inst combinationally from it.
//  Result: one-cycle read latency. Supports decode-side stall and branch/jump redirect.
// PARAMETERS
//  RESET_PC  32'h0000_0000  byte address of the first fetched instruction (bits [1:0] = 0)
//  CNT_W     32             width of the fetched-instruction counter
// PORTS
//  clk            in   1      clock, all state on posedge
//  rst            in   1      asynchronous, active-low reset (asserted when 0)
//  stall          in   1      decode cannot accept; hold current output
//  redirect_valid in   1      branch/jump taken; fetch restarts at redirect_pc
//  redirect_pc    in   32     byte target address
//  imem_addr      out  30     word address to the instruction ROM
//  imem_inst      in   32     ROM read data for the address presented the previous cycle
//  if_valid       out  1      if_inst/if_pc hold a real instruction
//  if_pc          out  32     byte PC of if_inst
//  if_inst        out  32     instruction word (= imem_inst)
//  if_pc_plus4    out  32     if_pc + 4, for link/branch computation
//  fetch_cnt      out  CNT_W  count of instructions handed to decode
//  misalign_err   out  1      sticky: a redirect target had bits [1:0] != 0
// BEHAVIOUR
//  State: fsm {BOOT, RUN}; req_pc[31:0] = byte PC of the word the ROM is returning now.
//  Reset (rst=0, async): fsm=BOOT, req_pc=RESET_PC, fetch_cnt=0, misalign_err=0.
//   During reset: if_valid=0 and imem_addr=RESET_PC[31:2].
//  nxt_pc, combinational, in priority order:
//   - redirect_valid : {redirect_pc[31:2],2'b00}
//   - fsm==BOOT      : RESET_PC
//   - stall          : req_pc; re-present the same address so the ROM output holds
//   - otherwise      : req_pc + 4, wrapping mod 2^32 (32'hFFFF_FFFC -> 0)
//  imem_addr = nxt_pc[31:2] every cycle. Posedge: req_pc <= nxt_pc.
//  BOOT: if_valid=0; next edge -> RUN unconditionally; stall is ignored in BOOT.
//  RUN: if_valid = !redirect_valid. if_pc=req_pc. if_inst=imem_inst. if_pc_plus4=req_pc+4.
//   - A redirect kills the word currently on the outputs (if_valid=0 that cycle).
//   - The next cycle outputs the target instruction with if_valid=1. Penalty: 1 bubble.
//  stall=1 in RUN with no redirect: if_valid/if_pc/if_inst are held cycle-for-cycle stable.
//  redirect_valid && stall in the same cycle: redirect wins; stall does not hold the dead word.
//  fetch_cnt: +1 on each posedge with if_valid && !stall. Wraps at 2^CNT_W.
//  misalign_err: set on redirect_valid with redirect_pc[1:0]!=0; target is truncated to a word.
//   Cleared only by reset.
//  Reset asserted mid-run: outputs drop immediately (async); fetch restarts via BOOT at RESET_PC.
//  Throughput: 1 instruction/cycle with stall=0 and no redirect.
// TESTING
//  1. Release reset, no stall, ROM prog 24170000,24100020,24080020 ->
//     cycle 1 if_valid=0 (BOOT); then if_pc=0,4,8 with if_inst as listed; fetch_cnt=3 after 3 valid.
//  2. stall=1 for 3 cycles while if_pc=4 -> if_pc=4, if_inst=24100020 held; imem_addr=1 held;
//     fetch_cnt frozen; resumes at 8 on release.
//  3. redirect_valid=1, redirect_pc=32'h1C while if_pc=8 -> if_valid=0 that cycle;
//     next cycle if_pc=1C, if_valid=1; imem_addr=7 in redirect cycle.
//  4. redirect + stall same cycle, target 32'h10 -> next cycle if_pc=10, valid; dead word not held.
//  5. redirect_pc=32'h0000_0016 -> fetch resumes at 32'h14; misalign_err=1 and stays 1 until reset.
//  6. Drop rst mid-stream at if_pc=14 -> outputs clear same cycle;
//     after release BOOT bubble, then if_pc=0; fetch_cnt=0.

Source files
------------

// File: rtl/ifetch_pc_gen.sv
// Instruction-fetch stage: owns the PC, addresses a 1-cycle-latency instruction ROM
// and pairs each returned word with its byte PC for decode.
module ifetch_pc_gen #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          CNT_W    = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             stall,
   input  logic             redirect_valid,
   input  logic [31:0]      redirect_pc,
   output logic [29:0]      imem_addr,
   input  logic [31:0]      imem_inst,
   output logic             if_valid,
   output logic [31:0]      if_pc,
   output logic [31:0]      if_inst,
   output logic [31:0]      if_pc_plus4,
   output logic [CNT_W-1:0] fetch_cnt,
   output logic             misalign_err,
   output logic             dbg_state
);

   typedef enum logic {BOOT = 1'b0, RUN = 1'b1} fsm_t;

   fsm_t             fsm_q, fsm_d;
   logic [31:0]      req_pc_q, req_pc_d;
   logic [CNT_W-1:0] fetch_cnt_q, fetch_cnt_d;
   logic             misalign_q, misalign_d;
   logic [31:0]      nxt_pc;

   // Handshake: a word transfers to decode on a cycle with if_valid=1 and stall=0.
   // While stalled the same address is re-presented so the ROM output holds;
   // a redirect overrides the stall and kills the word on the outputs.
   always_comb begin
      nxt_pc      = req_pc_q + 32'd4;
      fsm_d       = RUN;
      if_valid    = 1'b0;
      fetch_cnt_d = fetch_cnt_q;
      misalign_d  = misalign_q;

      if (redirect_valid) begin
         nxt_pc = {redirect_pc[31:2], 2'b00};
      end else if (fsm_q == BOOT) begin
         nxt_pc = RESET_PC;
      end else if (stall) begin
         nxt_pc = req_pc_q;
      end

      if (fsm_q == RUN) begin
         if_valid = !redirect_valid;
      end

      if (if_valid && !stall) begin
         fetch_cnt_d = fetch_cnt_q + CNT_W'(1);
      end

      if (redirect_valid && (redirect_pc[1:0] != 2'b00)) begin
         misalign_d = 1'b1;
      end

      req_pc_d = nxt_pc;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fsm_q       <= BOOT;
         req_pc_q    <= RESET_PC;
         fetch_cnt_q <= '0;
         misalign_q  <= 1'b0;
      end else begin
         fsm_q       <= fsm_d;
         req_pc_q    <= req_pc_d;
         fetch_cnt_q <= fetch_cnt_d;
         misalign_q  <= misalign_d;
      end
   end

   // Hold the ROM on the boot address while reset is asserted, whatever the inputs do.
   assign imem_addr    = rst ? nxt_pc[31:2] : RESET_PC[31:2];
   assign if_pc        = req_pc_q;
   assign if_inst      = imem_inst;
   assign if_pc_plus4  = req_pc_q + 32'd4;
   assign fetch_cnt    = fetch_cnt_q;
   assign misalign_err = misalign_q;
   assign dbg_state    = fsm_q;

endmodule

// File: tb/tb_ifetch_pc_gen.sv
// Bench for ifetch_pc_gen: directed vector table, randomized run against a
// program-order reference model, and a mid-stream reset sequence.
module tb_ifetch_pc_gen;

   logic        clk;
   logic        rst;
   logic        stall;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic [29:0] imem_addr;
   logic [31:0] imem_inst;
   logic        if_valid;
   logic [31:0] if_pc;
   logic [31:0] if_inst;
   logic [31:0] if_pc_plus4;
   logic [31:0] fetch_cnt;
   logic        misalign_err;
   logic        dbg_state;

   int checks;
   int errors;

   ifetch_pc_gen #(.RESET_PC(32'h0000_0000), .CNT_W(32)) dut (
      .clk            (clk),
      .rst            (rst),
      .stall          (stall),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .imem_addr      (imem_addr),
      .imem_inst      (imem_inst),
      .if_valid       (if_valid),
      .if_pc          (if_pc),
      .if_inst        (if_inst),
      .if_pc_plus4    (if_pc_plus4),
      .fetch_cnt      (fetch_cnt),
      .misalign_err   (misalign_err),
      .dbg_state      (dbg_state)
   );

   // clock / reset block
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // instruction ROM: address registered on posedge, data read combinationally
   logic [31:0] rom [64];
   logic [29:0] rom_addr_q;
   always @(posedge clk) rom_addr_q <= imem_addr;
   assign imem_inst = rom[rom_addr_q[5:0]];

   function automatic logic [31:0] rom_word(input logic [31:0] pc);
      logic [5:0] idx;
      idx = pc[7:2];
      return rom[idx];
   endfunction

   // reference model: program-order view of the fetch stream
   logic        m_boot;
   logic [31:0] m_pc;
   logic [31:0] m_cnt;
   logic        m_err;

   function automatic logic [31:0] m_next(input logic s, input logic rv, input logic [31:0] rpc);
      if (rv)     return rpc & 32'hFFFF_FFFC;
      if (m_boot) return 32'h0000_0000;
      if (s)      return m_pc;
      return m_pc + 32'd4;
   endfunction

   task automatic m_reset();
      m_boot = 1'b1;
      m_pc   = 32'h0;
      m_cnt  = 32'h0;
      m_err  = 1'b0;
   endtask

   task automatic m_advance(input logic s, input logic rv, input logic [31:0] rpc);
      logic v;
      v = !m_boot && !rv;
      if (v && !s) m_cnt = m_cnt + 32'd1;
      if (rv && (rpc[1:0] != 2'b00)) m_err = 1'b1;
      m_pc   = m_next(s, rv, rpc);
      m_boot = 1'b0;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   // directed vector table
   typedef struct {
      logic        s;
      logic        rv;
      logic [31:0] rpc;
      logic        ev;
      logic [31:0] epc;
      logic [31:0] einst;
      logic [29:0] eaddr;
      logic [31:0] ecnt;
      logic        eerr;
   } vec_t;

   vec_t vecs [13];

   // driver: apply inputs, compare at the falling edge, advance the model, move past the posedge
   task automatic step(input logic s, input logic rv, input logic [31:0] rpc, input int row);
      logic        ev;
      logic [31:0] ea;
      stall          = s;
      redirect_valid = rv;
      redirect_pc    = rpc;
      @(negedge clk);
      if (row >= 0) begin
         chk($sformatf("tab%0d_valid", row), {31'b0, if_valid}, {31'b0, vecs[row].ev});
         chk($sformatf("tab%0d_pc", row), if_pc, vecs[row].epc);
         chk($sformatf("tab%0d_pc4", row), if_pc_plus4, vecs[row].epc + 32'd4);
         if (vecs[row].ev)
            chk($sformatf("tab%0d_inst", row), if_inst, vecs[row].einst);
         chk($sformatf("tab%0d_addr", row), {2'b0, imem_addr}, {2'b0, vecs[row].eaddr});
         chk($sformatf("tab%0d_cnt", row), fetch_cnt, vecs[row].ecnt);
         chk($sformatf("tab%0d_err", row), {31'b0, misalign_err}, {31'b0, vecs[row].eerr});
      end else begin
         ev = !m_boot && !rv;
         ea = m_next(s, rv, rpc);
         chk("rnd_valid", {31'b0, if_valid}, {31'b0, ev});
         chk("rnd_pc", if_pc, m_pc);
         chk("rnd_pc4", if_pc_plus4, m_pc + 32'd4);
         if (ev) chk("rnd_inst", if_inst, rom_word(m_pc));
         chk("rnd_addr", {2'b0, imem_addr}, {2'b0, ea[31:2]});
         chk("rnd_cnt", fetch_cnt, m_cnt);
         chk("rnd_err", {31'b0, misalign_err}, {31'b0, m_err});
      end
      m_advance(s, rv, rpc);
      @(posedge clk);
      #1;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      for (int i = 0; i < 64; i++) rom[i] = 32'hA000_0000 + 32'(i);
      rom[0] = 32'h2417_0000;
      rom[1] = 32'h2410_0020;
      rom[2] = 32'h2408_0020;

      //            s     rv    rpc         ev    epc         einst       eaddr  ecnt   eerr
      vecs[0]  = '{1'b0, 1'b0, 32'h0,     1'b0, 32'h00, 32'h0,          30'd0, 32'd0, 1'b0};
      vecs[1]  = '{1'b0, 1'b0, 32'h0,     1'b1, 32'h00, 32'h2417_0000,  30'd1, 32'd0, 1'b0};
      vecs[2]  = '{1'b1, 1'b0, 32'h0,     1'b1, 32'h04, 32'h2410_0020,  30'd1, 32'd1, 1'b0};
      vecs[3]  = '{1'b1, 1'b0, 32'h0,     1'b1, 32'h04, 32'h2410_0020,  30'd1, 32'd1, 1'b0};
      vecs[4]  = '{1'b1, 1'b0, 32'h0,     1'b1, 32'h04, 32'h2410_0020,  30'd1, 32'd1, 1'b0};
      vecs[5]  = '{1'b0, 1'b0, 32'h0,     1'b1, 32'h04, 32'h2410_0020,  30'd2, 32'd1, 1'b0};
      vecs[6]  = '{1'b0, 1'b1, 32'h1C,    1'b0, 32'h08, 32'h2408_0020,  30'd7, 32'd2, 1'b0};
      vecs[7]  = '{1'b0, 1'b0, 32'h0,     1'b1, 32'h1C, 32'hA000_0007,  30'd8, 32'd2, 1'b0};
      vecs[8]  = '{1'b1, 1'b1, 32'h10,    1'b0, 32'h20, 32'hA000_0008,  30'd4, 32'd3, 1'b0};
      vecs[9]  = '{1'b0, 1'b0, 32'h0,     1'b1, 32'h10, 32'hA000_0004,  30'd5, 32'd3, 1'b0};
      vecs[10] = '{1'b0, 1'b1, 32'h16,    1'b0, 32'h14, 32'hA000_0005,  30'd5, 32'd4, 1'b0};
      vecs[11] = '{1'b0, 1'b0, 32'h0,     1'b1, 32'h14, 32'hA000_0005,  30'd6, 32'd4, 1'b1};
      vecs[12] = '{1'b0, 1'b0, 32'h0,     1'b1, 32'h18, 32'hA000_0006,  30'd7, 32'd5, 1'b1};

      rst            = 1'b0;
      stall          = 1'b0;
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0000_0040;
      m_reset();
      repeat (3) @(posedge clk);
      #1;
      chk("rst_valid", {31'b0, if_valid}, 32'h0);
      chk("rst_addr", {2'b0, imem_addr}, 32'h0);
      chk("rst_cnt", fetch_cnt, 32'h0);
      chk("rst_err", {31'b0, misalign_err}, 32'h0);
      redirect_valid = 1'b0;
      rst = 1'b1;

      for (int r = 0; r < 13; r++) step(vecs[r].s, vecs[r].rv, vecs[r].rpc, r);

      // wrap of the top word back to address 0
      step(1'b0, 1'b1, 32'hFFFF_FFFC, -1);
      step(1'b0, 1'b0, 32'h0, -1);
      step(1'b0, 1'b0, 32'h0, -1);

      for (int n = 0; n < 400; n++) begin
         logic        s;
         logic        rv;
         logic [31:0] rpc;
         s   = ($urandom_range(0, 2) == 0);
         rv  = ($urandom_range(0, 7) == 0);
         rpc = 32'($urandom_range(0, 255));
         if ($urandom_range(0, 3) == 0) rpc = rpc | 32'hFFFF_FF00;
         step(s, rv, rpc, -1);
      end

      // mid-stream reset while if_pc = 0x14
      step(1'b0, 1'b1, 32'h14, -1);
      stall          = 1'b0;
      redirect_valid = 1'b0;
      @(negedge clk);
      chk("pre_rst_pc", if_pc, 32'h14);
      chk("pre_rst_valid", {31'b0, if_valid}, 32'h1);
      #2;
      rst = 1'b0;
      #1;
      chk("async_valid", {31'b0, if_valid}, 32'h0);
      chk("async_pc", if_pc, 32'h0);
      chk("async_addr", {2'b0, imem_addr}, 32'h0);
      chk("async_cnt", fetch_cnt, 32'h0);
      chk("async_err", {31'b0, misalign_err}, 32'h0);
      m_reset();
      @(posedge clk);
      #1;
      rst = 1'b1;
      step(1'b0, 1'b0, 32'h0, -1);
      step(1'b0, 1'b0, 32'h0, -1);
      step(1'b0, 1'b0, 32'h0, -1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
